pulse_stretcher: RTL and testbench

- Converts single-cycle event pulses into clean level windows of fixed length, each followed by a guaranteed low gap. Every accepted input pulse therefore produces one distinct rising edge downstream.
- Sits between pulse-producing game logic (deal/hit/stand events) and level consumers: LED indicators, display blink logic, and edge detectors in other clock-rate paths.
- Pulses that arrive while a window is active are queued, up to a bounded depth, rather than merged.

---
 rtl/pulse_stretcher.sv | 142 ++++++++++++++
 tb/tb_pulse_stretcher.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle event pulses into fixed-length high
// windows, each followed by a guaranteed low gap. Pulses that arrive while a
// window or gap is in progress are counted, up to QUEUE_DEPTH, and replayed
// as further windows. Events beyond that depth are dropped and flagged.
module pulse_stretcher #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int QUEUE_DEPTH = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               pulse_in,
    output logic                               level_out,
    output logic                               busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending_cnt,
    output logic                               overflow
);

    localparam int PW   = $clog2(QUEUE_DEPTH + 1);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    // The counter holds "cycles remaining after this one", so a load of N-1
    // gives exactly N cycles in the state and zero marks the final cycle.
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] Q_MAX     = PW'(QUEUE_DEPTH);
    localparam logic [PW-1:0] Q_ONE     = PW'(1);

    // Reject parameter values that would make the counters meaningless.
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("pulse_stretcher: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("pulse_stretcher: GAP_CYCLES must be >= 1");
    end
    if (QUEUE_DEPTH < 1) begin : g_bad_depth
        $error("pulse_stretcher: QUEUE_DEPTH must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic            cnt_done;
    logic            last_gap;
    logic            have_pend;
    logic            q_full;
    logic            q_window;   // queue accepts/drops events this cycle
    logic            q_push;
    logic            q_drop;

    // Queue bookkeeping decoded from the current state. On the last GAP
    // cycle the incoming pulse is handled by the window hand-off instead, so
    // it never counts as a push or a drop there.
    always_comb begin
        cnt_done  = (cnt == '0);
        last_gap  = (state == GAP) && cnt_done;
        have_pend = (pending_cnt != '0);
        q_full    = (pending_cnt == Q_MAX);
        q_window  = ((state == HOLD) || (state == GAP)) && !last_gap;
        q_push    = q_window && pulse_in && !q_full;
        q_drop    = q_window && pulse_in &&  q_full;
    end

    // Window FSM with its registered outputs and the pending-event counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            level_out   <= 1'b0;
            busy        <= 1'b0;
            pending_cnt <= '0;
            overflow    <= 1'b0;
        end else begin
            // overflow is a strobe: one cycle per dropped event.
            overflow <= q_drop;

            if (q_push) begin
                pending_cnt <= pending_cnt + Q_ONE;
            end

            case (state)
                IDLE: begin
                    // A pulse while idle starts a window directly; it is
                    // never counted as pending.
                    if (pulse_in) begin
                        state     <= HOLD;
                        cnt       <= HOLD_LOAD;
                        level_out <= 1'b1;
                        busy      <= 1'b1;
                    end
                end

                HOLD: begin
                    if (cnt_done) begin
                        state     <= GAP;
                        cnt       <= GAP_LOAD;
                        level_out <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                GAP: begin
                    if (cnt_done) begin
                        if (have_pend || pulse_in) begin
                            // Next window starts right after the gap. A pulse
                            // arriving now replaces the queued event it
                            // consumes, so the count only drops without one.
                            state     <= HOLD;
                            cnt       <= HOLD_LOAD;
                            level_out <= 1'b1;
                            if (!pulse_in) begin
                                pending_cnt <= pending_cnt - Q_ONE;
                            end
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    level_out   <= 1'b0;
                    busy        <= 1'b0;
                    pending_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// timeline model (window start cycle + pending count).
module tb_pulse_stretcher;

    localparam int H  = 4;
    localparam int G  = 2;
    localparam int QD = 3;
    localparam int PW = $clog2(QD + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pulse_in = 1'b0;
    logic          level_out;
    logic          busy;
    logic [PW-1:0] pending_cnt;
    logic          overflow;

    pulse_stretcher #(
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .QUEUE_DEPTH (QD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pulse_in    (pulse_in),
        .level_out   (level_out),
        .busy        (busy),
        .pending_cnt (pending_cnt),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The model only remembers when the current window started (m_ws) and
    // how many events wait. Window occupies cycles m_ws .. m_ws+H+G-1, high
    // for the first H of them.
    int cyc     = 0;
    bit m_valid = 1'b0;
    bit m_win   = 1'b0;
    int m_ws    = 0;
    int m_pend  = 0;
    bit m_ovf   = 1'b0;

    function automatic bit m_busy_at(input int c);
        return m_win && (c >= m_ws) && (c <= m_ws + H + G - 1);
    endfunction

    always @(posedge clk) begin
        int t;
        t = cyc;
        if (rst) begin
            m_valid = 1'b1;
            m_win   = 1'b0;
            m_pend  = 0;
            m_ovf   = 1'b0;
        end else begin
            m_ovf = 1'b0;
            if (!m_busy_at(t)) begin
                if (pulse_in) begin
                    m_win = 1'b1;
                    m_ws  = t + 1;
                end
            end else if (t == m_ws + H + G - 1) begin
                if (m_pend > 0 || pulse_in) m_ws = t + 1;
                else m_win = 1'b0;
                if (!pulse_in && m_pend > 0) m_pend = m_pend - 1;
            end else if (pulse_in) begin
                if (m_pend < QD) m_pend = m_pend + 1;
                else m_ovf = 1'b1;
            end
        end
        cyc = t + 1;
    end

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_fail = 0;
    int rise_cnt = 0;
    int ovf_cnt = 0;
    bit prev_lvl = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs, move to the middle of the next cycle and
    // compare every output against the model.
    task automatic tick(input bit p, input bit r);
        bit eb;
        bit el;
        pulse_in = p;
        rst      = r;
        @(negedge clk);
        if (m_valid) begin
            eb = m_busy_at(cyc);
            el = eb && ((cyc - m_ws) < H);
            chk("model_level",    {31'd0, level_out}, {31'd0, el});
            chk("model_busy",     {31'd0, busy},      {31'd0, eb});
            chk("model_pending",  32'(pending_cnt),   32'(m_pend));
            chk("model_overflow", {31'd0, overflow},  {31'd0, m_ovf});
        end
        if (level_out && !prev_lvl) rise_cnt++;
        prev_lvl = level_out;
        if (overflow) ovf_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    initial begin
        int prob;

        // Reset state
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("rst_level",   {31'd0, level_out}, 32'd0);
        chk("rst_busy",    {31'd0, busy},      32'd0);
        chk("rst_pending", 32'(pending_cnt),   32'd0);
        chk("rst_ovf",     {31'd0, overflow},  32'd0);
        idle(5);

        // Single pulse: high 4, low 2, then idle
        tick(1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            chk("single_level", {31'd0, level_out}, (k <= 4) ? 32'd1 : 32'd0);
            chk("single_busy",  {31'd0, busy},      (k <= 6) ? 32'd1 : 32'd0);
            chk("single_pend",  32'(pending_cnt),   32'd0);
            tick(1'b0, 1'b0);
        end
        idle(5);

        // Five back-to-back events: one dropped, four windows
        rise_cnt = 0;
        ovf_cnt  = 0;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        chk("burst_ovf_hi", {31'd0, overflow}, 32'd1);
        chk("burst_pend",   32'(pending_cnt),  32'd3);
        tick(1'b0, 1'b0);
        chk("burst_ovf_lo", {31'd0, overflow}, 32'd0);
        idle(40);
        chk("burst_windows", 32'(rise_cnt), 32'd4);
        chk("burst_drops",   32'(ovf_cnt),  32'd1);

        // Full queue plus pulse on the last gap cycle: no drop
        idle(5);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
        chk("full_pend", 32'(pending_cnt), 32'd3);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("full_gap_level", {31'd0, level_out}, 32'd0);
        chk("full_gap_busy",  {31'd0, busy},      32'd1);
        tick(1'b1, 1'b0);
        chk("full_lastgap_ovf",  {31'd0, overflow},  32'd0);
        chk("full_lastgap_pend", 32'(pending_cnt),   32'd3);
        chk("full_next_hold",    {31'd0, level_out}, 32'd1);
        idle(40);

        // Reset in the middle of a window with two pending events
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("midrst_pre_pend",  32'(pending_cnt),   32'd2);
        chk("midrst_pre_level", {31'd0, level_out}, 32'd1);
        tick(1'b0, 1'b1);
        chk("midrst_level", {31'd0, level_out}, 32'd0);
        chk("midrst_busy",  {31'd0, busy},      32'd0);
        chk("midrst_pend",  32'(pending_cnt),   32'd0);
        rise_cnt = 0;
        idle(10);
        chk("midrst_no_resume", 32'(rise_cnt), 32'd0);
        tick(1'b1, 1'b0);
        chk("midrst_new_level", {31'd0, level_out}, 32'd1);
        idle(4);
        chk("midrst_new_end", {31'd0, level_out}, 32'd0);
        idle(5);

        // Pulse on the last gap cycle with an empty queue
        tick(1'b1, 1'b0);
        idle(4);
        chk("lastgap_low1", {31'd0, level_out}, 32'd0);
        tick(1'b0, 1'b0);
        chk("lastgap_low2", {31'd0, level_out}, 32'd0);
        tick(1'b1, 1'b0);
        chk("lastgap_level", {31'd0, level_out}, 32'd1);
        chk("lastgap_pend",  32'(pending_cnt),   32'd0);
        chk("lastgap_busy",  {31'd0, busy},      32'd1);
        idle(10);

        // Random traffic with varying density and occasional resets
        prob = 20;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) prob = $urandom_range(5, 95);
            tick($urandom_range(0, 99) < prob, $urandom_range(0, 149) == 0);
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
